// File: rtl/iob_axi_ram_responder_pkg.sv
// Shared codes for the AXI RAM responder: burst types, responses,
// FSM state encoding and byte-offset width helper.
package iob_axi_ram_responder_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_DATA
    } state_t;

    function automatic int off_width(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/iob_axi_burst_addr.sv
// Next beat address and burst legality for one AXI address channel.
// IOB_AXI_RAM_RESPONDER_WRAP_EN enables WRAP bursts.
module iob_axi_burst_addr
    import iob_axi_ram_responder_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 8,
    parameter int OFF_W  = 2
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [2:0]        size_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              err_o
);

`ifdef IOB_AXI_RAM_RESPONDER_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              len_ok;
    logic              unaligned;
    logic              size_err;

    always_comb begin
        step      = ADDR_W'(1) << size_i;
        incr      = addr_i + step;
        // Wrap window is (len+1) transfers of 2^size bytes.
        wrap_mask = ((ADDR_W'(len_i) + ADDR_W'(1)) << size_i) - ADDR_W'(1);
        len_ok    = (len_i == LEN_W'(1)) || (len_i == LEN_W'(3)) ||
                    (len_i == LEN_W'(7)) || (len_i == LEN_W'(15));
        unaligned = |(addr_i & (step - ADDR_W'(1)));
        size_err  = size_i > 3'(OFF_W);

        next_addr_o = addr_i;
        err_o       = size_err;
        unique case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_INCR:  next_addr_o = incr;
            BURST_WRAP: begin
                next_addr_o = (addr_i & ~wrap_mask) | (incr & wrap_mask);
                err_o = size_err | ~WRAP_EN | ~len_ok | unaligned;
            end
            default:     err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/iob_axi_ram_responder.sv
// AXI4 responder backed by an on-chip byte-enabled RAM, one burst at a time.
// IOB_AXI_RAM_RESPONDER_WRAP_EN enables WRAP bursts (see iob_axi_burst_addr).
module iob_axi_ram_responder
    import iob_axi_ram_responder_pkg::*;
#(
    parameter int AXI_ID_W   = 4,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int MEM_ADDR_W = 16
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int OFF_W  = off_width(AXI_DATA_W);
    localparam int STRB_W = AXI_DATA_W / 8;

    state_t                  state_q;
    logic                    run_q;
    logic                    wr_pri_q;
    logic [AXI_ID_W-1:0]     id_q;
    logic [AXI_ADDR_W-1:0]   addr_q;
    logic [AXI_LEN_W-1:0]    len_q;
    logic [AXI_LEN_W-1:0]    cnt_q;
    logic [2:0]              size_q;
    logic [1:0]              burst_q;
    logic                    err_q;
    logic                    wl_err_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    iss_done_q;
    logic                    s1_v_q;
    logic                    s1_last_q;
    logic                    rvalid_q;
    logic                    rlast_q;
    logic [1:0]              rresp_q;
    logic [AXI_DATA_W-1:0]   rdata_q;
    logic [AXI_DATA_W-1:0]   ram_q;

    logic                    idle;
    logic                    grant_w;
    logic                    grant_r;
    logic                    w_hs;
    logic                    w_last_beat;
    logic                    wlast_bad;
    logic                    out_free;
    logic                    rd_issue;
    logic                    ram_we;
    logic [MEM_ADDR_W-1:0]   widx;

    logic [AXI_ADDR_W-1:0]   ba_addr;
    logic [AXI_LEN_W-1:0]    ba_len;
    logic [2:0]              ba_size;
    logic [1:0]              ba_burst;
    logic [AXI_ADDR_W-1:0]   ba_next;
    logic                    ba_err;

    logic [AXI_DATA_W-1:0]   mem [2**MEM_ADDR_W];

    assign idle    = (state_q == ST_IDLE) & run_q;
    assign grant_w = idle & axi_awvalid_i & (~axi_arvalid_i | wr_pri_q);
    assign grant_r = idle & axi_arvalid_i & (~axi_awvalid_i | ~wr_pri_q);

    assign axi_awready_o = grant_w;
    assign axi_arready_o = grant_r;
    assign axi_wready_o  = (state_q == ST_WR_DATA);
    assign axi_bvalid_o  = bvalid_q;
    assign axi_bresp_o   = bresp_q;
    assign axi_bid_o     = id_q;
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rlast_o   = rlast_q;
    assign axi_rid_o     = id_q;

    assign w_hs        = (state_q == ST_WR_DATA) & axi_wvalid_i;
    assign w_last_beat = (cnt_q == len_q);
    assign wlast_bad   = axi_wlast_i != w_last_beat;

    // A read is issued only when the RAM output stage will be free.
    assign out_free = ~rvalid_q | axi_rready_i;
    assign rd_issue = (state_q == ST_RD_DATA) & ~iss_done_q &
                      (~s1_v_q | out_free);

    // In IDLE the checker sees the granted channel; in a burst, the latched one.
    assign ba_addr  = idle ? (grant_r ? axi_araddr_i  : axi_awaddr_i)  : addr_q;
    assign ba_len   = idle ? (grant_r ? axi_arlen_i   : axi_awlen_i)   : len_q;
    assign ba_size  = idle ? (grant_r ? axi_arsize_i  : axi_awsize_i)  : size_q;
    assign ba_burst = idle ? (grant_r ? axi_arburst_i : axi_awburst_i) : burst_q;

    iob_axi_burst_addr #(
        .ADDR_W (AXI_ADDR_W),
        .LEN_W  (AXI_LEN_W),
        .OFF_W  (OFF_W)
    ) u_burst_addr (
        .addr_i      (ba_addr),
        .len_i       (ba_len),
        .size_i      (ba_size),
        .burst_i     (ba_burst),
        .next_addr_o (ba_next),
        .err_o       (ba_err)
    );

    assign widx   = addr_q[MEM_ADDR_W+OFF_W-1:OFF_W];
    assign ram_we = w_hs & ~err_q;

    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb_i[b]) begin
                    mem[widx][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
                end
            end
        end
        if (rd_issue) begin
            ram_q <= mem[widx];
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            wr_pri_q   <= 1'b1;
            id_q       <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            err_q      <= 1'b0;
            wl_err_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            iss_done_q <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_last_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            run_q <= 1'b1;
            unique case (state_q)
                ST_IDLE: begin
                    if (grant_w | grant_r) begin
                        id_q       <= grant_r ? axi_arid_i : axi_awid_i;
                        addr_q     <= ba_addr;
                        len_q      <= ba_len;
                        size_q     <= ba_size;
                        burst_q    <= ba_burst;
                        err_q      <= ba_err;
                        cnt_q      <= '0;
                        wl_err_q   <= 1'b0;
                        iss_done_q <= 1'b0;
                        // Loser of a tie wins the next one.
                        if (axi_awvalid_i & axi_arvalid_i) begin
                            wr_pri_q <= grant_r;
                        end
                        state_q <= grant_w ? ST_WR_DATA : ST_RD_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (w_hs) begin
                        addr_q <= ba_next;
                        cnt_q  <= cnt_q + AXI_LEN_W'(1);
                        if (w_last_beat) begin
                            state_q  <= ST_WR_RESP;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q | wl_err_q | wlast_bad) ?
                                        RESP_SLVERR : RESP_OKAY;
                        end else begin
                            wl_err_q <= wl_err_q | wlast_bad;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (axi_bready_i) begin
                        bvalid_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RD_DATA: begin
                    if (rd_issue) begin
                        addr_q <= ba_next;
                        cnt_q  <= cnt_q + AXI_LEN_W'(1);
                        if (cnt_q == len_q) begin
                            iss_done_q <= 1'b1;
                        end
                    end
                    if (rvalid_q & axi_rready_i & rlast_q) begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase

            if (rd_issue) begin
                s1_v_q    <= 1'b1;
                s1_last_q <= (cnt_q == len_q);
            end else if (out_free) begin
                s1_v_q <= 1'b0;
            end

            if (out_free) begin
                rvalid_q <= s1_v_q;
                rlast_q  <= s1_v_q & s1_last_q;
                rdata_q  <= (s1_v_q & ~err_q) ? ram_q : '0;
                rresp_q  <= (s1_v_q & err_q) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

endmodule

// File: tb/tb_iob_axi_ram_responder.sv
// Directed self-checking bench for iob_axi_ram_responder.
// Expected WRAP results follow IOB_AXI_RAM_RESPONDER_WRAP_EN.
module tb_iob_axi_ram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid, arid, bid, rid;
    logic [23:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, arvalid, arready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic        bvalid, bready, rlast, rvalid, rready;

    int tests = 0;
    int fails = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    logic [15:0] rlastv;
    logic [1:0]  rresp_or;
    logic [3:0]  rid_s, bid_s;
    logic [1:0]  bresp_s;
    int          rcnt, rlat, unstable, bdly, wdly0;

    always #5 clk = ~clk;

    iob_axi_ram_responder dut (
        .clk_i(clk), .arst_n_i(rst_n),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen),
        .axi_awsize_i(awsize), .axi_awburst_i(awburst),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid),
        .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen),
        .axi_arsize_i(arsize), .axi_arburst_i(arburst),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp),
        .axi_rlast_o(rlast), .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [23:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b,
                           input logic [3:0] id);
        int k;
        k = 0;
        awaddr = a; awlen = l; awsize = s; awburst = b; awid = id;
        awvalid = 1'b1;
        #1;
        while (!awready && k < 50) begin tick(); k++; end
        if (!awready) begin
            tests++; fails++;
            $display("FAIL aw_timeout: awready %b want 1", awready);
        end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [23:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b,
                           input logic [3:0] id);
        int k;
        k = 0;
        araddr = a; arlen = l; arsize = s; arburst = b; arid = id;
        arvalid = 1'b1;
        #1;
        while (!arready && k < 50) begin tick(); k++; end
        if (!arready) begin
            tests++; fails++;
            $display("FAIL ar_timeout: arready %b want 1", arready);
        end
        tick();
        arvalid = 1'b0;
    endtask

    task automatic w_send(input int n, input logic [3:0] st,
                          input logic [15:0] flip);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            wdata = wbuf[i]; wstrb = st;
            wlast = (i == n - 1) ^ flip[i];
            wvalid = 1'b1;
            #1;
            while (!wready && k < 50) begin tick(); k++; end
            if (i == 0) wdly0 = k;
            if (!wready) begin
                tests++; fails++;
                $display("FAIL w_timeout: beat %0d wready 0 want 1", i);
            end
            tick();
        end
        wvalid = 1'b0;
        wlast = 1'b0;
    endtask

    task automatic b_recv();
        int k;
        k = 0;
        bready = 1'b1;
        while (!bvalid && k < 50) begin tick(); k++; end
        if (!bvalid) begin
            tests++; fails++;
            $display("FAIL b_timeout: bvalid 0 want 1");
        end
        bdly = k; bresp_s = bresp; bid_s = bid;
        tick();
        bready = 1'b0;
    endtask

    task automatic r_recv(input int n, input int mode);
        int cyc;
        int got;
        logic stall;
        logic [31:0] pd;
        logic pl;
        cyc = 0; got = 0; stall = 1'b0; pd = '0; pl = 1'b0;
        rlat = -1; unstable = 0; rlastv = '0; rresp_or = '0;
        while (got < n && cyc < 300) begin
            rready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (stall && (!rvalid || rdata !== pd || rlast !== pl))
                unstable++;
            if (rvalid && rlat < 0) rlat = cyc;
            stall = rvalid && !rready;
            pd = rdata; pl = rlast;
            if (rvalid && rready) begin
                rbuf[got] = rdata; rlastv[got] = rlast;
                rresp_or = rresp_or | rresp; rid_s = rid;
                got++;
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        rcnt = got;
        if (got < n) begin
            tests++; fails++;
            $display("FAIL r_timeout: beats %0d want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        tests++;
        if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
            fails++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {awready, arready, wready, bvalid, rvalid});
        end
        tests++;
        if ({bresp, rresp, rdata, bid, rid, rlast} !== '0) begin
            fails++;
            $display("FAIL reset_fields: bresp %h rresp %h rdata %h", bresp, rresp, rdata);
        end
        awvalid = 1'b1;
        #1;
        tests++;
        if (awready !== 1'b0) begin
            fails++;
            $display("FAIL reset_awready: got %b want 0", awready);
        end
        awvalid = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_incr();
        logic [31:0] exp [4];
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int i = 0; i < 4; i++) wbuf[i] = exp[i];
        aw_send(24'h100, 8'd3, 3'd2, 2'b01, 4'd5);
        w_send(4, 4'hF, 16'h0);
        b_recv();
        tests++;
        if (wdly0 !== 0) begin
            fails++; $display("FAIL incr_wready_lat: got %0d want 0", wdly0);
        end
        tests++;
        if (bdly !== 0 || bresp_s !== 2'b00 || bid_s !== 4'd5) begin
            fails++;
            $display("FAIL incr_b: dly %0d resp %h id %h want 0 0 5", bdly, bresp_s, bid_s);
        end
        ar_send(24'h100, 8'd3, 3'd2, 2'b01, 4'd3);
        r_recv(4, 0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rbuf[i] !== exp[i]) begin
                fails++;
                $display("FAIL incr_rdata%0d: got %h want %h", i, rbuf[i], exp[i]);
            end
        end
        tests++;
        if (rlastv[3:0] !== 4'b1000 || rresp_or !== 2'b00 || rid_s !== 4'd3) begin
            fails++;
            $display("FAIL incr_rmeta: last %b resp %h id %h want 1000 0 3",
                     rlastv[3:0], rresp_or, rid_s);
        end
        tests++;
        if (rlat !== 2) begin
            fails++; $display("FAIL incr_rlat: got %0d want 2", rlat);
        end
    endtask

    task automatic test_byte_write();
        wbuf[0] = 32'h0;
        aw_send(24'h200, 8'd0, 3'd2, 2'b01, 4'd1);
        w_send(1, 4'hF, 16'h0);
        b_recv();
        wbuf[0] = 32'hAABBCCDD;
        aw_send(24'h200, 8'd0, 3'd2, 2'b01, 4'd1);
        w_send(1, 4'h2, 16'h0);
        b_recv();
        ar_send(24'h200, 8'd0, 3'd2, 2'b01, 4'd1);
        r_recv(1, 0);
        tests++;
        if (rbuf[0] !== 32'h0000CC00) begin
            fails++; $display("FAIL byte_write: got %h want 0000cc00", rbuf[0]);
        end
    endtask

    task automatic test_tie();
        awaddr = 24'h300; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awid = 4'd1;
        araddr = 24'h300; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 4'd2;
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        tests++;
        if ({awready, arready} !== 2'b10) begin
            fails++; $display("FAIL tie1_grant: aw/ar %b want 10", {awready, arready});
        end
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        wbuf[0] = 32'h5A5A5A5A;
        w_send(1, 4'hF, 16'h0);
        b_recv();
        tests++;
        if (bresp_s !== 2'b00 || bid_s !== 4'd1) begin
            fails++; $display("FAIL tie1_b: resp %h id %h want 0 1", bresp_s, bid_s);
        end
        awvalid = 1'b1; arvalid = 1'b1;
        #1;
        tests++;
        if ({awready, arready} !== 2'b01) begin
            fails++; $display("FAIL tie2_grant: aw/ar %b want 01", {awready, arready});
        end
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        r_recv(1, 0);
        tests++;
        if (rbuf[0] !== 32'h5A5A5A5A || rid_s !== 4'd2) begin
            fails++; $display("FAIL tie2_r: data %h id %h want 5a5a5a5a 2", rbuf[0], rid_s);
        end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000 + i;
        aw_send(24'h400, 8'd7, 3'd2, 2'b01, 4'd7);
        w_send(8, 4'hF, 16'h0);
        b_recv();
        ar_send(24'h400, 8'd7, 3'd2, 2'b01, 4'd7);
        r_recv(8, 1);
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (rbuf[i] !== 32'h1000 + i) begin
                fails++;
                $display("FAIL stall_rdata%0d: got %h want %h", i, rbuf[i], 32'h1000 + i);
            end
        end
        tests++;
        if (unstable !== 0 || rlastv[7:0] !== 8'h80) begin
            fails++;
            $display("FAIL stall_hold: unstable %0d last %b want 0 10000000", unstable, rlastv[7:0]);
        end
        tests++;
        if (rvalid !== 1'b0) begin
            fails++; $display("FAIL stall_extra_beat: rvalid %b want 0", rvalid);
        end
    endtask

    task automatic test_wlast();
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h500 + i;
        aw_send(24'h500, 8'd3, 3'd2, 2'b01, 4'd9);
        w_send(4, 4'hF, 16'h0002);
        b_recv();
        tests++;
        if (bresp_s !== 2'b10 || bdly !== 0) begin
            fails++; $display("FAIL wlast_early: resp %h dly %0d want 2 0", bresp_s, bdly);
        end
        aw_send(24'h500, 8'd3, 3'd2, 2'b01, 4'd9);
        w_send(4, 4'hF, 16'h0008);
        b_recv();
        tests++;
        if (bresp_s !== 2'b10) begin
            fails++; $display("FAIL wlast_missing: resp %h want 2", bresp_s);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp [4];
        logic [1:0]  exp_b;
`ifdef IOB_AXI_RAM_RESPONDER_WRAP_EN
        exp = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
        exp_b = 2'b00;
`else
        exp = '{32'h11, 32'h22, 32'h33, 32'h44};
        exp_b = 2'b10;
`endif
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + i;
        aw_send(24'h108, 8'd3, 3'd2, 2'b10, 4'd2);
        w_send(4, 4'hF, 16'h0);
        b_recv();
        tests++;
        if (bresp_s !== exp_b) begin
            fails++; $display("FAIL wrap_bresp: got %h want %h", bresp_s, exp_b);
        end
        ar_send(24'h100, 8'd3, 3'd2, 2'b01, 4'd2);
        r_recv(4, 0);
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (rbuf[i] !== exp[i]) begin
                fails++;
                $display("FAIL wrap_mem%0d: got %h want %h", i, rbuf[i], exp[i]);
            end
        end
        ar_send(24'h108, 8'd3, 3'd2, 2'b10, 4'd2);
        r_recv(4, 0);
        tests++;
`ifdef IOB_AXI_RAM_RESPONDER_WRAP_EN
        if (rbuf[0] !== 32'hA0 || rbuf[2] !== 32'hA2 || rresp_or !== 2'b00) begin
`else
        if (rbuf[0] !== 32'h0 || rbuf[2] !== 32'h0 || rresp_or !== 2'b10 || rcnt !== 4) begin
`endif
            fails++;
            $display("FAIL wrap_read: b0 %h b2 %h resp %h beats %0d", rbuf[0], rbuf[2], rresp_or, rcnt);
        end
    endtask

    task automatic test_errors();
        wbuf[0] = 32'h00600600;
        aw_send(24'h600, 8'd0, 3'd2, 2'b01, 4'd1);
        w_send(1, 4'hF, 16'h0);
        b_recv();
        wbuf[0] = 32'hDEADBEEF;
        aw_send(24'h600, 8'd0, 3'd3, 2'b01, 4'd1);
        w_send(1, 4'hF, 16'h0);
        b_recv();
        tests++;
        if (bresp_s !== 2'b10) begin
            fails++; $display("FAIL size_err_bresp: got %h want 2", bresp_s);
        end
        aw_send(24'h600, 8'd0, 3'd2, 2'b11, 4'd1);
        w_send(1, 4'hF, 16'h0);
        b_recv();
        tests++;
        if (bresp_s !== 2'b10) begin
            fails++; $display("FAIL rsvd_burst_bresp: got %h want 2", bresp_s);
        end
        ar_send(24'h600, 8'd0, 3'd2, 2'b01, 4'd1);
        r_recv(1, 0);
        tests++;
        if (rbuf[0] !== 32'h00600600 || rresp_or !== 2'b00) begin
            fails++; $display("FAIL err_discard: got %h resp %h want 00600600 0", rbuf[0], rresp_or);
        end
        ar_send(24'h600, 8'd1, 3'd3, 2'b01, 4'd1);
        r_recv(2, 0);
        tests++;
        if (rbuf[0] !== 32'h0 || rbuf[1] !== 32'h0 || rresp_or !== 2'b10) begin
            fails++; $display("FAIL size_err_read: got %h %h resp %h want 0 0 2", rbuf[0], rbuf[1], rresp_or);
        end
    endtask

    task automatic test_reset_mid_burst();
        int got;
        int k;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h7000 + i;
        aw_send(24'h700, 8'd7, 3'd2, 2'b01, 4'd4);
        w_send(8, 4'hF, 16'h0);
        b_recv();
        ar_send(24'h700, 8'd7, 3'd2, 2'b01, 4'd4);
        rready = 1'b1;
        got = 0; k = 0;
        while (got < 3 && k < 50) begin
            if (rvalid) got++;
            tick();
            k++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (rvalid !== 1'b0 || rlast !== 1'b0) begin
            fails++; $display("FAIL rst_mid_rvalid: rvalid %b rlast %b want 0 0", rvalid, rlast);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        rready = 1'b0;
        tick();
        tests++;
        if (rvalid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_resume: rvalid %b want 0", rvalid);
        end
        ar_send(24'h700, 8'd1, 3'd2, 2'b01, 4'd6);
        r_recv(2, 0);
        tests++;
        if (rbuf[0] !== 32'h7000 || rbuf[1] !== 32'h7001 || rid_s !== 4'd6) begin
            fails++;
            $display("FAIL rst_mid_data: got %h %h id %h want 7000 7001 6", rbuf[0], rbuf[1], rid_s);
        end
        tests++;
        if (rlat !== 2 || rlastv[1:0] !== 2'b10) begin
            fails++; $display("FAIL rst_mid_timing: lat %0d last %b want 2 10", rlat, rlastv[1:0]);
        end
    endtask

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        test_reset();
        test_incr();
        test_byte_write();
        test_tie();
        test_stall();
        test_wlast();
        test_wrap();
        test_errors();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
